sigmoid_lut_arbiter: RTL and testbench
======================================

# sigmoid_lut_arbiter

Shares one synchronous sigmoid LUT (384 entries, magnitude range [0, 6], S1.5.6 input) between N_REQ gate requesters of the LSTM cell, such as the input, forget and output gates. It arbitrates requests and computes the LUT address from the input magnitude, clamping at the top of the range. It issues the ROM read, applies the symmetry σ(−x) = 1 − σ(x) to the returned value, and returns the ID-tagged result through a 2-entry output FIFO with backpressure. It sits between the gate pre-activation accumulators and the shared sigmoid ROM.

## Interface
- N_REQ, 3, number of requesters (2..4)
- ID_WIDTH, 2, width of requester ID; 2^ID_WIDTH ≥ N_REQ
- INPUT_WIDTH, 12, S1.5.6 sign-magnitude input
- LUT_SIZE, 384, ROM depth
- ADDR_WIDTH, 9, ROM address width
- OUT_WIDTH, 16, unsigned U0.16 sigmoid value
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  request valid, one bit per requester
- req_data  in  N_REQ*INPUT_WIDTH  requester i occupies bits [i*INPUT_WIDTH +: INPUT_WIDTH]
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when valid and ready are both high
- lut_en  out  1  ROM read enable
- lut_addr  out  ADDR_WIDTH  ROM address
- lut_data  in  OUT_WIDTH  ROM data, valid exactly 1 cycle after lut_en
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  ID_WIDTH  index of the originating requester
- rsp_data  out  OUT_WIDTH  σ(x) in U0.16
- rsp_sat  out  1  |x| exceeded the LUT range; the address was clamped
- busy  out  1  a ROM read is pending or the FIFO is non-empty

## Operation
- **Issue stage (combinational within grant cycle t):**
  - A grant is allowed iff fifo_count + rom_pending − deq_this_cycle < 2, where deq_this_cycle = rsp_valid & rsp_ready.
  - When allowed and any req_valid bit is set, exactly one req_ready bit goes high. req_ready depends combinationally on req_valid.
- **Address calculation:**
  - mag = req_data[INPUT_WIDTH-2:0].
  - If mag ≥ LUT_SIZE: lut_addr = LUT_SIZE−1 and sat = 1.
  - Otherwise lut_addr = mag[ADDR_WIDTH-1:0] and sat = 0.
  - lut_en = 1 during the grant cycle only.
- **ROM stage (cycle t+1):**
  - The registered sign, id and sat values are combined with lut_data.
  - result = sign ? (2^OUT_WIDTH − lut_data) : lut_data, computed modulo 2^OUT_WIDTH.
  - The ROM guarantees lut_data ≥ 0x8000, so no wrap occurs. −0 therefore yields 0x8000.
  - The result is pushed into the FIFO at the end of t+1.
- **FIFO:**
  - 2 entries holding {id, sat, data}. Head is presented on the rsp_* outputs.
  - Push and pop in the same cycle are legal. Overflow is impossible by the grant rule.
- **Arbitration:** see Configuration.
  - rr_ptr holds the index of the last granted requester.
  - Priority search starts at rr_ptr+1, wrapping at N_REQ−1 → 0.
  - rr_ptr updates only on a completed transfer.
- **Reset (any time):**
  - req_ready = 0, lut_en = 0, lut_addr = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_sat = 0, busy = 0.
  - rom_pending is cleared, the FIFO is emptied and rr_ptr = N_REQ−1, so requester 0 wins first.
  - In-flight reads are discarded.

## Timing
- Latency: 2 cycles from grant to rsp_valid. A grant at edge t gives rsp_valid after edge t+2, assuming an empty FIFO.
- Throughput: 1 result/cycle while rsp_ready = 1.
- Under sustained rsp_ready = 0, at most 2 grants occur: one goes in flight and the second fills the FIFO. req_ready then stays 0 until a pop.
- rsp_* are held stable while rsp_valid = 1 and rsp_ready = 0.
- Simultaneous grant + push + pop: legal. Occupancy is computed with the pop counted.
- rst asserts asynchronously and deasserts synchronously to clk externally; the block requires no extra deassertion handling.

## Configuration
- SIGMOID_ARB_RR_EN defined: round-robin arbitration as above.
- SIGMOID_ARB_RR_EN undefined: fixed priority, where the lowest index wins. rr_ptr is removed.

## Test plan
- **Single request:**
  - Stimulus: reset, then req 0 with x = 0x040 (+1.0). Expected: lut_addr = 64 in the grant cycle and rsp_valid 2 cycles later with rsp_data = lut[64], rsp_id = 0, rsp_sat = 0.
  - Stimulus: x = 0x840 (−1.0). Expected: rsp_data = 0x10000 − lut[64].
- **Clamp:**
  - Stimulus: x = 0x1FF (+7.98). Expected: lut_addr = 383, rsp_sat = 1.
  - Stimulus: x = 0x17F (5.98). Expected: lut_addr = 383, rsp_sat = 0.
  - Stimulus: x = 0x800 (−0). Expected: rsp_data = 0x8000.
- **Contention, all 3 requesters valid continuously:**
  - With SIGMOID_ARB_RR_EN defined: grants are 0, 1, 2, 0, … and rsp_id follows the same sequence.
  - Without SIGMOID_ARB_RR_EN: requester 0 receives every grant.
- **Backpressure:**
  - Stimulus: rsp_ready = 0 with continuous requests. Expected: exactly 2 grants, then req_ready = 0 and busy = 1.
  - Stimulus: release rsp_ready. Expected: results drain in order with no loss or duplication.
- **Reset mid-flight:**
  - Stimulus: assert rst the cycle after a grant. Expected: all outputs 0 immediately.
  - After rst is released, the next grant goes to requester 0 and the discarded result never appears.

Source files
------------

// File: rtl/sigmoid_lut_arbiter.sv
// Shares one synchronous sigmoid ROM between N_REQ gate requesters and returns ID-tagged results via a 2-entry FIFO.
// Optional feature macro: SIGMOID_ARB_RR_EN (round-robin arbitration); undefined gives fixed lowest-index priority.
module sigmoid_lut_arbiter #(
    parameter int N_REQ       = 3,
    parameter int ID_WIDTH    = 2,
    parameter int INPUT_WIDTH = 12,
    parameter int LUT_SIZE    = 384,
    parameter int ADDR_WIDTH  = 9,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*INPUT_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         lut_en,
    output logic [ADDR_WIDTH-1:0]        lut_addr,
    input  logic [OUT_WIDTH-1:0]         lut_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_WIDTH-1:0]          rsp_id,
    output logic [OUT_WIDTH-1:0]         rsp_data,
    output logic                         rsp_sat,
    output logic                         busy
);
    localparam int MAG_W = INPUT_WIDTH - 1;
    localparam logic [MAG_W-1:0]      LUT_LIMIT = MAG_W'(LUT_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = ADDR_WIDTH'(LUT_SIZE - 1);

    logic [MAG_W-1:0]    mag_arr [N_REQ];
    logic [N_REQ-1:0]    sign_vec;
    logic [ID_WIDTH-1:0] cand_idx [N_REQ];

    logic                grant_any;
    logic [ID_WIDTH-1:0] grant_idx;
    logic                grant;
    logic                can_issue;
    logic                deq;
    logic [2:0]          occ;

    logic [MAG_W-1:0]      sel_mag;
    logic                  sel_sign;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  sat_next;

    logic                pend_reg;
    logic                sign_reg;
    logic [ID_WIDTH-1:0] id_reg;
    logic                sat_reg;
    logic [OUT_WIDTH-1:0] result;

    logic [OUT_WIDTH-1:0] fifo_data_reg [2];
    logic [ID_WIDTH-1:0]  fifo_id_reg   [2];
    logic                 fifo_sat_reg  [2];
    logic                 wr_ptr_reg;
    logic                 rd_ptr_reg;
    logic [1:0]           count_reg;
    logic                 push;

    genvar gi;

    // Split the packed request bus into per-requester magnitude and sign.
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign mag_arr[gi]  = req_data[gi*INPUT_WIDTH +: MAG_W];
            assign sign_vec[gi] = req_data[gi*INPUT_WIDTH + INPUT_WIDTH - 1];
        end
    endgenerate

`ifdef SIGMOID_ARB_RR_EN
    localparam logic [ID_WIDTH:0] N_REQ_W = (ID_WIDTH+1)'(N_REQ);
    logic [ID_WIDTH-1:0] rr_ptr_reg;

    // Candidate k is the k-th requester after the last one granted, wrapping at N_REQ.
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [ID_WIDTH:0] sum;
            assign sum = {1'b0, rr_ptr_reg} + (ID_WIDTH+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= N_REQ_W) ? ID_WIDTH'(sum - N_REQ_W) : sum[ID_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= ID_WIDTH'(N_REQ - 1);
        end else if (grant) begin
            rr_ptr_reg <= grant_idx;
        end
    end
`else
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = ID_WIDTH'(gi);
        end
    endgenerate
`endif

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_any && req_valid[cand_idx[k]]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx[k];
            end
        end
    end

    // Occupancy counts the in-flight read and credits a pop happening this cycle.
    assign deq       = rsp_valid & rsp_ready;
    assign occ       = {1'b0, count_reg} + {2'b00, pend_reg} - {2'b00, deq};
    assign can_issue = (occ < 3'd2);

    always_comb begin
        req_ready = '0;
        if (!rst && can_issue && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign grant    = |req_ready;
    assign sel_mag  = mag_arr[grant_idx];
    assign sel_sign = sign_vec[grant_idx];

    always_comb begin
        addr_next = sel_mag[ADDR_WIDTH-1:0];
        sat_next  = 1'b0;
        if (sel_mag >= LUT_LIMIT) begin
            addr_next = ADDR_MAX;
            sat_next  = 1'b1;
        end
    end

    assign lut_en   = grant;
    assign lut_addr = grant ? addr_next : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_reg <= 1'b0;
            sign_reg <= 1'b0;
            id_reg   <= '0;
            sat_reg  <= 1'b0;
        end else begin
            pend_reg <= grant;
            if (grant) begin
                sign_reg <= sel_sign;
                id_reg   <= grant_idx;
                sat_reg  <= sat_next;
            end
        end
    end

    // Negative inputs use sigma(-x) = 1 - sigma(x); the ROM never returns below 0x8000.
    assign result = sign_reg ? ({OUT_WIDTH{1'b0}} - lut_data) : lut_data;
    assign push   = pend_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
            for (int e = 0; e < 2; e++) begin
                fifo_data_reg[e] <= '0;
                fifo_id_reg[e]   <= '0;
                fifo_sat_reg[e]  <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data_reg[wr_ptr_reg] <= result;
                fifo_id_reg[wr_ptr_reg]   <= id_reg;
                fifo_sat_reg[wr_ptr_reg]  <= sat_reg;
                wr_ptr_reg                <= ~wr_ptr_reg;
            end
            if (deq) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, deq})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rsp_valid = (count_reg != 2'd0);
    assign rsp_data  = rsp_valid ? fifo_data_reg[rd_ptr_reg] : '0;
    assign rsp_id    = rsp_valid ? fifo_id_reg[rd_ptr_reg]   : '0;
    assign rsp_sat   = rsp_valid ? fifo_sat_reg[rd_ptr_reg]  : 1'b0;
    assign busy      = pend_reg | rsp_valid;

endmodule

// File: tb/tb_sigmoid_lut_arbiter.sv
// Directed bench for sigmoid_lut_arbiter: ROM model lut[a] = 0x8000 + 85*a, hand-computed expectations.
`timescale 1ns/1ps
module tb_sigmoid_lut_arbiter;
    localparam int N_REQ = 3;
    localparam int ID_WIDTH = 2;
    localparam int INPUT_WIDTH = 12;
    localparam int ADDR_WIDTH = 9;
    localparam int OUT_WIDTH = 16;
`ifdef SIGMOID_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ*INPUT_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]             req_ready;
    logic                         lut_en;
    logic [ADDR_WIDTH-1:0]        lut_addr;
    logic [OUT_WIDTH-1:0]         lut_data = '0;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [ID_WIDTH-1:0]          rsp_id;
    logic [OUT_WIDTH-1:0]         rsp_data;
    logic                         rsp_sat;
    logic                         busy;

    int total = 0;
    int bad   = 0;
    int gcount = 0;
    int exp_q[$];
    // lut[16], lut[32], lut[48] for requesters 0, 1, 2 during contention
    logic [15:0] exp_data [3] = '{16'h8550, 16'h8AA0, 16'h8FF0};

    sigmoid_lut_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .lut_en(lut_en), .lut_addr(lut_addr), .lut_data(lut_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_sat(rsp_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lut_en) lut_data <= 16'h8000 + 16'(lut_addr) * 16'd85;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=0x%0h", tag, got);
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_req_ready"}, 32'(req_ready), 0);
        check_val({tag, "_lut_en"},    32'(lut_en), 0);
        check_val({tag, "_lut_addr"},  32'(lut_addr), 0);
        check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check_val({tag, "_rsp_data"},  32'(rsp_data), 0);
        check_val({tag, "_rsp_id"},    32'(rsp_id), 0);
        check_val({tag, "_rsp_sat"},   32'(rsp_sat), 0);
        check_val({tag, "_busy"},      32'(busy), 0);
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        gcount = 0;
        @(posedge clk); #1;
    endtask

    task automatic single(input string tag, input int id, input logic [11:0] x,
                          input int eaddr, input logic [15:0] edata, input bit esat);
        req_data = '0;
        req_data[id*INPUT_WIDTH +: INPUT_WIDTH] = x;
        req_valid = 3'(1 << id);
        #1;
        check_val({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
        check_val({tag, "_lut_en"}, 32'(lut_en), 1);
        check_val({tag, "_addr"}, 32'(lut_addr), 32'(eaddr));
        @(posedge clk); #1;
        req_valid = '0;
        check_val({tag, "_early_valid"}, 32'(rsp_valid), 0);
        check_val({tag, "_busy"}, 32'(busy), 1);
        @(posedge clk); #1;
        check_val({tag, "_valid"}, 32'(rsp_valid), 1);
        check_val({tag, "_data"}, 32'(rsp_data), 32'(edata));
        check_val({tag, "_id"}, 32'(rsp_id), 32'(id));
        check_val({tag, "_sat"}, 32'(rsp_sat), 32'(esat));
        @(posedge clk); #1;
        check_val({tag, "_idle"}, 32'(busy), 0);
    endtask

    // Inputs are driven at posedge+1; this checks the cycle at posedge+2 and advances one clock.
    task automatic step(input string tag, input bit exp_grant);
        int eid;
        #1;
        if (exp_grant) begin
            eid = RR ? (gcount % N_REQ) : 0;
            check_val({tag, "_grant"}, 32'(req_ready), 32'(1 << eid));
            exp_q.push_back(eid);
            gcount++;
        end else begin
            check_val({tag, "_nogrant"}, 32'(req_ready), 0);
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check_val({tag, "_extra_rsp"}, 32'(rsp_valid), 0);
            end else begin
                eid = exp_q.pop_front();
                check_val({tag, "_rsp_id"}, 32'(rsp_id), 32'(eid));
                check_val({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_data[eid]));
                check_val({tag, "_rsp_sat"}, 32'(rsp_sat), 0);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_ready = 1'b1;
        req_valid = 3'b111;
        req_data  = {12'h040, 12'h040, 12'h040};
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        req_valid = '0;
        rst = 1'b0;
        @(posedge clk); #1;

        single("pos1",   0, 12'h040,  64, 16'h9540, 1'b0);
        single("neg1",   0, 12'h840,  64, 16'h6AC0, 1'b0);
        single("clamp",  1, 12'h1FF, 383, 16'hFF2B, 1'b1);
        single("edge",   2, 12'h17F, 383, 16'hFF2B, 1'b0);
        single("negzero",0, 12'h800,   0, 16'h8000, 1'b0);

        do_reset();
        req_data  = {12'h030, 12'h020, 12'h010};
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) step("cont", 1'b1);
        req_valid = '0;
        for (int i = 0; i < 4; i++) step("cont_drain", 1'b0);
        check_val("cont_all_returned", 32'(exp_q.size()), 0);

        do_reset();
        rsp_ready = 1'b0;
        req_valid = 3'b111;
        step("bp", 1'b1);
        step("bp", 1'b1);
        for (int i = 0; i < 3; i++) step("bp_full", 1'b0);
        check_val("bp_busy", 32'(busy), 1);
        check_val("bp_valid", 32'(rsp_valid), 1);
        check_val("bp_head_id", 32'(rsp_id), 0);
        check_val("bp_head_data", 32'(rsp_data), 32'(exp_data[0]));
        rsp_ready = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 4; i++) step("bp_drain", 1'b0);
        check_val("bp_all_returned", 32'(exp_q.size()), 0);
        check_val("bp_idle", 32'(busy), 0);

        req_data  = {12'h040, 12'h020, 12'h010};
        req_valid = 3'b100;
        #1;
        check_val("mf_grant2", 32'(req_ready), 32'b100);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_idle("mf_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        gcount = 0;
        req_data  = {12'h030, 12'h020, 12'h010};
        req_valid = 3'b111;
        step("mf_after", 1'b1);
        req_valid = '0;
        for (int i = 0; i < 4; i++) step("mf_drain", 1'b0);
        check_val("mf_all_returned", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
